reg_fpr3: RTL
=============

# reg_fpr3

Parametrised third-generation floating-point register file for the FPU. It holds two banks (FR, XF) of NREGS words each plus an internal FPUL register, and serves three combinational read ports and one registered write port in 32-bit or 64-bit pair mode. It adds an FPSCR.FR bank swap, a load-pending scoreboard with a stall output, and a sequenced bank-clear engine, so the register arrays can map to distributed RAM. It sits between decode/operand fetch and the FPU/load-store writeback.

## Interface
Parameters:
- NREGS, 16: words per bank; legal values 8 or 16.
- WIDTH, 32: word width; a pair is 2*WIDTH.

Ports:
- clock  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- regIdRs, regIdRt, regIdRn  in  7  read-port register IDs.
- regValRs, regValRt, regValRn  out  2*WIDTH  read data.
- regIdRo  in  7  write ID.
- regValRo  in  2*WIDTH  write data.
- regWrEn  in  1  write strobe.
- regMode  in  2  bit0=1 selects 64-bit pair reads.
- regStMode  in  2  bit0=1 selects 64-bit pair writes.
- ctlFrSwap  in  1  FPSCR.FR; 1 swaps FR and XF banks for all ports.
- ctlLdIssue  in  1  a load targeting ctlLdId has been issued.
- ctlLdId  in  7  load destination ID, interpreted under regStMode.
- ctlClear  in  1  request a full bank clear.
- regBusy  out  1  clear engine active.
- regStall  out  1  a read port references a pending register.
- ctlOutFpul  out  WIDTH  current FPUL.

## Operation
- ID map (package constants): FR n = 7'h40+n, XF n = 7'h50+n, FPUL = 7'h68. Any other ID reads 0, and writes to it are dropped.
- With ctlFrSwap=1, FR IDs address the XF array and XF IDs address the FR array. The swap is combinational and applies to reads, writes and the scoreboard.
- 32-bit read: value is {0, word}.
- 64-bit read of FR 2k: value is {FR[2k], FR[2k+1]}.
- 64-bit read of FR 2k+1: value is {XF[2k], XF[2k+1]}.
- XF IDs in 64-bit mode read 0.
- FPUL reads {0, FPUL} in both modes.
- Writes use the same mapping under regStMode. In 64-bit mode, [2*WIDTH-1:WIDTH] goes to the even word. FPUL takes [WIDTH-1:0].
- Scoreboard: one pending bit per physical word; a pair load sets two bits.
  - ctlLdIssue sets the bits for ctlLdId.
  - Any regWrEn covering a word clears that word's bit.
  - Simultaneous issue and write to the same word: set wins.
- regStall = OR over the three read ports of the pending bits covered by each port's ID.
- Clear FSM states:
  - CLR: idx runs 0..NREGS-1. Each cycle it zeroes FR[idx] and XF[idx]. In the first CLR cycle it zeroes FPUL and all pending bits.
  - IDLE.
- FSM transitions:
  - Reset enters CLR with idx=0.
  - CLR moves to IDLE after idx=NREGS-1.
  - IDLE moves to CLR on ctlClear.
  - ctlClear during CLR restarts at idx=0.
- While in CLR: regBusy=1, read data = 0, regStall=0, writes and ctlLdIssue are ignored.

## Timing
- Reads are combinational from current state. Writes and scoreboard updates land on the next rising edge.
- Clear takes NREGS cycles. regBusy falls on the edge that completes idx=NREGS-1.
- Reset values: regValRs/Rt/Rn=0, regBusy=1, regStall=0, ctlOutFpul=0, pending=0, idx=0.
- Reset asserted mid-operation aborts the current activity. The clear restarts from idx=0 after reset deassertion.
- Without bypass, a read of the word being written in the same cycle returns the old value. That read also still sees the old pending bit, so the stall persists that cycle.

## Configuration
- FPR_BYPASS_EN defined: a read whose mapped word matches an active write in the same cycle returns regValRo's relevant half. That word's pending bit is also masked from regStall that cycle.
- FPR_BYPASS_EN undefined: no forwarding, old value returned (as in Timing). This saves the comparators.

## Structure
- Shared package fpr_pkg holds:
  - ID bases FR_BASE, XF_BASE, FPUL_ID;
  - the mode-bit positions;
  - the clear FSM state enum.
- Sub-module fpr_scoreboard holds:
  - pending bits;
  - set/clear logic;
  - the three-port stall compare.
- Bank arrays, ID decode, bypass and the clear FSM live in reg_fpr3.

## Test plan
- Reset, then NREGS=16: regBusy=1 for exactly 16 cycles; after that, FR3 reads 64'h0.
- 32-bit write FR5=32'h3F800000: read FR5 next cycle = 64'h000000003F800000. Same-cycle read returns 0 with bypass off, 3F800000 with bypass on.
- 64-bit write FR2=64'h400921FB54442D18, then ctlFrSwap=1: FR2 (64-bit) reads 0, XF2 (32-bit) reads 32'h400921FB.
- ctlLdIssue on FR7, then read FR7: regStall=1. Write FR7 next cycle: regStall=0 on the following cycle. Issue and write to FR7 in the same cycle: regStall=1 afterwards.
- Write FPUL=32'hDEADBEEF: ctlOutFpul=32'hDEADBEEF. Then ctlClear: FPUL=0 one cycle later. ctlClear again at idx=9: regBusy holds a further 16 cycles.

Source files
------------

// File: rtl/fpr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpr_pkg
//  Purpose  : Shared constants, types and the register-ID decoder for the
//             third-generation FPU register file.
//  Revision : 1.0  initial release
// ============================================================================
package fpr_pkg;

   // Register ID map
   localparam logic [6:0] FR_BASE = 7'h40;
   localparam logic [6:0] XF_BASE = 7'h50;
   localparam logic [6:0] FPUL_ID = 7'h68;

   // Bit of regMode / regStMode that selects 64-bit pair access
   localparam int MODE_PAIR_BIT = 0;

   // Clear engine states
   typedef enum logic [0:0] {
      ST_CLR  = 1'b0,
      ST_IDLE = 1'b1
   } clrState_t;

   // Decoded physical location of a register ID
   typedef struct packed {
      logic       fpul;   // ID names FPUL
      logic       word;   // ID names a bank word (or word pair)
      logic       pair;   // 64-bit pair access
      logic       bank;   // 0 = FR array, 1 = XF array (after swap)
      logic [3:0] idx;    // word index (even word for pairs)
   } fprLoc_t;

   // Map an ID onto a physical bank/word. Pair IDs FR 2k / FR 2k+1 select
   // the FR / XF pair at index 2k; the FR swap just flips the bank bit.
   function automatic fprLoc_t fprDecode(input logic [6:0] id,
                                         input logic       pairMode,
                                         input logic       swap,
                                         input int         nregs);
      fprLoc_t loc;
      loc = '0;
      if (id == FPUL_ID) begin
         loc.fpul = 1'b1;
      end else if (id[6:4] == FR_BASE[6:4] && int'(id[3:0]) < nregs) begin
         loc.word = 1'b1;
         if (pairMode) begin
            loc.pair = 1'b1;
            loc.bank = id[0] ^ swap;
            loc.idx  = {id[3:1], 1'b0};
         end else begin
            loc.bank = swap;
            loc.idx  = id[3:0];
         end
      end else if (id[6:4] == XF_BASE[6:4] && int'(id[3:0]) < nregs && !pairMode) begin
         loc.word = 1'b1;
         loc.bank = ~swap;
         loc.idx  = id[3:0];
      end
      return loc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpr_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fpr_scoreboard
//  Purpose  : Load-pending bits, one per physical bank word, and the stall
//             compare against the combined read-port coverage.
//  Revision : 1.0  initial release
// ============================================================================
module fpr_scoreboard
   import fpr_pkg::*;
#(
   parameter int NWORDS = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_busy,
   input  logic              i_clearAll,
   input  logic [NWORDS-1:0] i_ldMask,
   input  logic [NWORDS-1:0] i_wrMask,
   input  logic [NWORDS-1:0] i_rdMask,
   input  logic [NWORDS-1:0] i_fwdMask,
   output logic              o_stall
);

   logic [NWORDS-1:0] r_pending;

   // Writes retire pending words; a same-cycle load issue re-arms them (set wins)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
      end else if (i_clearAll) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~i_wrMask) | i_ldMask;
      end
   end

   // Stall when any read port touches a still-pending, non-forwarded word
   always_comb begin
      o_stall = !i_busy && (|(i_rdMask & r_pending & ~i_fwdMask));
   end

endmodule
`default_nettype wire

// File: rtl/reg_fpr3.sv
`default_nettype none
// ============================================================================
//  Module   : reg_fpr3
//  Purpose  : FR/XF banked floating-point register file with FPUL, three
//             combinational read ports, one write port, FR bank swap,
//             load scoreboard and a sequenced bank-clear engine.
//  Options  : FPR_BYPASS_EN - forward same-cycle write data to read ports.
//  Revision : 1.0  initial release
// ============================================================================
module reg_fpr3
   import fpr_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [6:0]         regIdRs,
   input  logic [6:0]         regIdRt,
   input  logic [6:0]         regIdRn,
   output logic [2*WIDTH-1:0] regValRs,
   output logic [2*WIDTH-1:0] regValRt,
   output logic [2*WIDTH-1:0] regValRn,
   input  logic [6:0]         regIdRo,
   input  logic [2*WIDTH-1:0] regValRo,
   input  logic               regWrEn,
   input  logic [1:0]         regMode,
   input  logic [1:0]         regStMode,
   input  logic               ctlFrSwap,
   input  logic               ctlLdIssue,
   input  logic [6:0]         ctlLdId,
   input  logic               ctlClear,
   output logic               regBusy,
   output logic               regStall,
   output logic [WIDTH-1:0]   ctlOutFpul
);

   localparam int c_NWORDS = 2 * NREGS;
   localparam int c_IDXW   = $clog2(NREGS);
   localparam int c_PW     = c_IDXW + 1;
   localparam logic [c_IDXW-1:0] c_IDX_LAST = c_IDXW'(NREGS - 1);

   clrState_t           r_state;
   logic [c_IDXW-1:0]   r_idx;
   logic                r_busy;
   logic [WIDTH-1:0]    r_fpul;

   fprLoc_t w_locRs, w_locRt, w_locRn, w_locRo, w_locLd;
   logic    w_wrEn, w_ldEn, w_clrFirst, w_wrFpul;
   logic    w_unusedModeBits;
   logic [c_NWORDS-1:0] w_wrMask, w_ldMask, w_rdMask, w_fwdMask;
   logic [c_NWORDS-1:0][WIDTH-1:0] w_eff;
   logic [WIDTH-1:0]    w_effFpul;

   // Physical word p is {bank, idx}; a pair covers the even word and its odd partner
   function automatic logic wordHit(input fprLoc_t loc, input logic [c_PW-1:0] p);
      logic [c_PW-1:0] base, odd;
      base = {loc.bank, loc.idx[c_IDXW-1:0]};
      odd  = {loc.bank, loc.idx[c_IDXW-1:1], 1'b1};
      return loc.word && (p == base || (loc.pair && p == odd));
   endfunction

   function automatic logic [2*WIDTH-1:0] readLoc(input fprLoc_t loc);
      logic [c_PW-1:0]    base, odd;
      logic [2*WIDTH-1:0] v;
      base = {loc.bank, loc.idx[c_IDXW-1:0]};
      odd  = {loc.bank, loc.idx[c_IDXW-1:1], 1'b1};
      v    = '0;
      if (loc.fpul)
         v = {{WIDTH{1'b0}}, w_effFpul};
      else if (loc.word && loc.pair)
         v = {w_eff[base], w_eff[odd]};
      else if (loc.word)
         v = {{WIDTH{1'b0}}, w_eff[base]};
      return v;
   endfunction

   assign w_locRs = fprDecode(regIdRs, regMode[MODE_PAIR_BIT],   ctlFrSwap, NREGS);
   assign w_locRt = fprDecode(regIdRt, regMode[MODE_PAIR_BIT],   ctlFrSwap, NREGS);
   assign w_locRn = fprDecode(regIdRn, regMode[MODE_PAIR_BIT],   ctlFrSwap, NREGS);
   assign w_locRo = fprDecode(regIdRo, regStMode[MODE_PAIR_BIT], ctlFrSwap, NREGS);
   assign w_locLd = fprDecode(ctlLdId, regStMode[MODE_PAIR_BIT], ctlFrSwap, NREGS);

   // Only the pair-select bit of each mode field carries meaning
   assign w_unusedModeBits = ^{regMode, regStMode};

   assign w_wrEn     = regWrEn && !r_busy;
   assign w_ldEn     = ctlLdIssue && !r_busy;
   assign w_wrFpul   = w_wrEn && w_locRo.fpul;
   assign w_clrFirst = r_busy && (r_idx == '0);

   // Per-word storage, write/clear enables and port coverage masks
   for (genvar gp = 0; gp < c_NWORDS; gp++) begin : g_word
      localparam logic [c_PW-1:0] c_P = c_PW'(gp);
      logic [WIDTH-1:0] r_word;
      logic [WIDTH-1:0] w_data;
      logic             w_clrWord;

      // Pair writes put the upper half in the even word
      assign w_data    = (w_locRo.pair && !c_P[0]) ? regValRo[2*WIDTH-1:WIDTH]
                                                   : regValRo[WIDTH-1:0];
      assign w_clrWord = r_busy && (c_P[c_IDXW-1:0] == r_idx);
      assign w_wrMask[gp] = w_wrEn && wordHit(w_locRo, c_P);
      assign w_ldMask[gp] = w_ldEn && wordHit(w_locLd, c_P);
      assign w_rdMask[gp] = wordHit(w_locRs, c_P) | wordHit(w_locRt, c_P) |
                            wordHit(w_locRn, c_P);

      // Bank word: zeroed by the clear engine, otherwise loaded by the write port
      always_ff @(posedge clock) begin
         if (w_clrWord)
            r_word <= '0;
         else if (w_wrMask[gp])
            r_word <= w_data;
      end

`ifdef FPR_BYPASS_EN
      assign w_eff[gp] = w_wrMask[gp] ? w_data : r_word;
`else
      assign w_eff[gp] = r_word;
`endif
   end

`ifdef FPR_BYPASS_EN
   assign w_effFpul = w_wrFpul ? regValRo[WIDTH-1:0] : r_fpul;
   assign w_fwdMask = w_wrMask;
`else
   assign w_effFpul = r_fpul;
   assign w_fwdMask = '0;
`endif

   // FPUL: flushed on the first clear cycle, otherwise loaded from the low half
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_fpul <= '0;
      else if (w_clrFirst)
         r_fpul <= '0;
      else if (w_wrFpul)
         r_fpul <= regValRo[WIDTH-1:0];
   end

   // Clear sequencer: sweeps idx over both banks, restartable by ctlClear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_CLR;
         r_idx   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            ST_CLR: begin
               if (ctlClear) begin
                  r_idx <= '0;
               end else if (r_idx == c_IDX_LAST) begin
                  r_state <= ST_IDLE;
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx <= r_idx + c_IDXW'(1);
               end
            end
            ST_IDLE: begin
               if (ctlClear) begin
                  r_state <= ST_CLR;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_CLR;
               r_idx   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   fpr_scoreboard #(
      .NWORDS (c_NWORDS)
   ) u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .i_busy     (r_busy),
      .i_clearAll (w_clrFirst),
      .i_ldMask   (w_ldMask),
      .i_wrMask   (w_wrMask),
      .i_rdMask   (w_rdMask),
      .i_fwdMask  (w_fwdMask),
      .o_stall    (regStall)
   );

   // Read ports return zero while the clear engine owns the banks
   always_comb begin
      regValRs = r_busy ? '0 : readLoc(w_locRs);
      regValRt = r_busy ? '0 : readLoc(w_locRt);
      regValRn = r_busy ? '0 : readLoc(w_locRn);
   end

   assign regBusy    = r_busy;
   assign ctlOutFpul = r_fpul;

endmodule
`default_nettype wire
